// File: rtl/s3g_tx_arbiter_pkg.sv
// Shared definitions for the s3g_tx arbiter: sequencer states, requester
// indices, default limits and the payload length legality check.
package s3g_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_FETCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_FIN   = 3'd4
  } arb_state_t;

  localparam int NUM_REQ = 3;
  localparam int REQ_CMD = 0;
  localparam int REQ_EVT = 1;
  localparam int REQ_TEL = 2;

  localparam int DEF_MAX_LEN      = 64;
  localparam int DEF_STARVE_LIMIT = 4;

  function automatic logic len_ok(input logic [7:0] len, input int max_len);
    return (len != 8'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/s3g_tx_prio_rr.sv
// Winner selection: command replies first, events and telemetry alternate,
// and a saturating counter forces a low-priority grant after a run of commands.
module s3g_tx_prio_rr
  import s3g_tx_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   i_req,
  input  logic         i_take,
  output logic [2:0]   o_win
);

  localparam int CW = $clog2(STARVE_LIMIT + 2);

  logic [CW-1:0] r_starve_cnt;
  logic          r_rr_tel;
  logic          w_lo_pend;
  logic          w_starved;
  logic [2:0]    w_rr_win;

  always_comb begin
    w_lo_pend = i_req[REQ_EVT] | i_req[REQ_TEL];
    w_starved = (r_starve_cnt == CW'(STARVE_LIMIT));
    w_rr_win  = 3'b000;
    if (i_req[REQ_EVT] && i_req[REQ_TEL]) begin
      w_rr_win = r_rr_tel ? 3'b100 : 3'b010;
    end else if (i_req[REQ_EVT]) begin
      w_rr_win = 3'b010;
    end else if (i_req[REQ_TEL]) begin
      w_rr_win = 3'b100;
    end
    o_win = 3'b000;
    if (i_req[REQ_CMD] && !(w_lo_pend && w_starved)) begin
      o_win = 3'b001;
    end else begin
      o_win = w_rr_win;
    end
  end

  // Only accepted packets move the counter and the pointer; rejected
  // requests leave arbitration history untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_rr_tel     <= 1'b0;
    end else if (i_take) begin
      if (o_win[REQ_CMD]) begin
        if (w_lo_pend && !w_starved) begin
          r_starve_cnt <= r_starve_cnt + CW'(1);
        end
      end else if (o_win[REQ_EVT]) begin
        r_starve_cnt <= '0;
        r_rr_tel     <= 1'b1;
      end else if (o_win[REQ_TEL]) begin
        r_starve_cnt <= '0;
        r_rr_tel     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/s3g_tx_arbiter.sv
// Shares one s3g_tx between command, event and telemetry sources, streaming
// the winner's payload byte by byte from its read buffer.
module s3g_tx_arbiter
  import s3g_tx_arbiter_pkg::*;
#(
  parameter int MAX_LEN      = DEF_MAX_LEN,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [23:0] req_len,
  output logic [7:0]  rd_addr,
  input  logic [23:0] rd_data,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic [2:0]  err,
  output logic        pkt_start,
  output logic [7:0]  pkt_len,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        pkt_last,
  output logic        busy
);

  // out_valid/out_ready: a byte moves on a rising edge where both are high;
  // out_valid never drops and out_data never changes until that edge.

  arb_state_t r_state;
  logic [2:0] r_grant;
  logic [2:0] r_done;
  logic [2:0] r_err;
  logic       r_pkt_start;
  logic [7:0] r_pkt_len;
  logic [7:0] r_addr;
  logic [7:0] r_out_data;
  logic       r_out_valid;
  logic       r_pkt_last;

  logic [2:0] w_win;
  logic       w_take;
  logic       w_take_ok;
  logic [7:0] w_win_len;
  logic [7:0] w_lane_data;
  logic       w_hs;
  logic       w_advance;

  always_comb begin
    w_win_len   = 8'd0;
    w_lane_data = 8'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win[i])   w_win_len   = req_len[8*i +: 8];
      if (r_grant[i]) w_lane_data = rd_data[8*i +: 8];
    end
  end

  assign w_take    = (r_state == ST_IDLE) && (|req);
  assign w_take_ok = w_take && len_ok(w_win_len, MAX_LEN);
  assign w_hs      = (r_state == ST_SEND) && r_out_valid && out_ready;
  assign w_advance = w_hs && !r_pkt_last;

  s3g_tx_prio_rr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio_rr (
    .clk    (clk),
    .rst    (rst),
    .i_req  (req),
    .i_take (w_take_ok),
    .o_win  (w_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= 3'b000;
      r_done      <= 3'b000;
      r_err       <= 3'b000;
      r_pkt_start <= 1'b0;
      r_pkt_len   <= 8'd0;
      r_addr      <= 8'd0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_pkt_last  <= 1'b0;
    end else begin
      r_pkt_start <= 1'b0;
      r_done      <= 3'b000;
      r_err       <= 3'b000;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_state <= ST_START;
            r_addr  <= 8'd0;
            if (w_take_ok) begin
              r_grant     <= w_win;
              r_pkt_start <= 1'b1;
              r_pkt_len   <= w_win_len;
            end else begin
              r_err <= w_win;
            end
          end
        end
        ST_START: begin
          r_state <= (|r_grant) ? ST_FETCH : ST_IDLE;
        end
        ST_FETCH: begin
          r_out_data  <= w_lane_data;
          r_out_valid <= 1'b1;
          r_pkt_last  <= (r_addr == r_pkt_len - 8'd1);
          r_state     <= ST_SEND;
        end
        ST_SEND: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_pkt_last  <= 1'b0;
            if (r_pkt_last) begin
              r_done  <= r_grant;
              r_grant <= 3'b000;
              r_state <= ST_FIN;
            end else begin
              r_addr  <= r_addr + 8'd1;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The buffers answer one cycle after the address, so the next index is
  // presented during the accepting cycle to have its byte ready in FETCH.
  assign rd_addr   = r_addr + 8'(w_advance);
  assign grant     = r_grant;
  assign done      = r_done;
  assign err       = r_err;
  assign pkt_start = r_pkt_start;
  assign pkt_len   = r_pkt_len;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign pkt_last  = r_pkt_last;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_s3g_tx_arbiter.sv
// Bench for s3g_tx_arbiter: directed scenarios plus randomized request mixes,
// checked by a decoupled monitor against a packet-level reference model.
module tb_s3g_tx_arbiter;

  localparam int MAX_LEN      = 64;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] req_len;
  logic [7:0]  rd_addr;
  logic [23:0] rd_data;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic [2:0]  err;
  logic        pkt_start;
  logic [7:0]  pkt_len;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        pkt_last;
  logic        busy;

  always #5 clk = ~clk;

  s3g_tx_arbiter #(
    .MAX_LEN      (MAX_LEN),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_len   (req_len),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .pkt_start (pkt_start),
    .pkt_len   (pkt_len),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pkt_last  (pkt_last),
    .busy      (busy)
  );

  // Requester payload buffers: registered read, one cycle after rd_addr.
  logic [7:0] mem [3][256];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) rd_data[8*i +: 8] <= mem[i][rd_addr];
  end

  typedef struct {
    int idx;
    bit is_err;
    int len;
  } pkt_t;

  pkt_t       pkt_q[$];
  logic [7:0] exp_q[$];
  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the arbitration rules applied to the set of requesters
  // that still have packets outstanding.
  int m_starve;
  bit m_pref_tel;

  function automatic int model_pick(input bit [2:0] pend);
    bit lo_pend;
    lo_pend = pend[1] | pend[2];
    if (pend[0] && !(lo_pend && m_starve == STARVE_LIMIT)) return 0;
    if (pend[1] && pend[2]) return m_pref_tel ? 2 : 1;
    return pend[1] ? 1 : 2;
  endfunction

  function automatic void model_commit(input int w, input bit [2:0] pend);
    if (w == 0) begin
      if ((pend[1] | pend[2]) && m_starve < STARVE_LIMIT) m_starve++;
    end else begin
      m_starve   = 0;
      m_pref_tel = (w == 1);
    end
  endfunction

  function automatic void model_reset();
    m_starve   = 0;
    m_pref_tel = 1'b0;
  endfunction

  // Per-requester plan for one iteration.
  int plen [3][4];
  int pcnt [3];
  int pnext[3];

  task automatic issue_iter();
    int rem[3];
    int nx[3];
    bit [2:0] pend;
    pkt_t p;
    for (int i = 0; i < 3; i++) begin
      rem[i] = pcnt[i];
      nx[i]  = 0;
    end
    pend = {rem[2] > 0, rem[1] > 0, rem[0] > 0};
    while (pend != 3'b000) begin
      p.idx    = model_pick(pend);
      p.len    = plen[p.idx][nx[p.idx]];
      p.is_err = (p.len == 0) || (p.len > MAX_LEN);
      pkt_q.push_back(p);
      if (!p.is_err) begin
        for (int k = 0; k < p.len; k++) exp_q.push_back(mem[p.idx][k]);
        model_commit(p.idx, pend);
      end
      nx[p.idx]++;
      rem[p.idx]--;
      pend = {rem[2] > 0, rem[1] > 0, rem[0] > 0};
    end
  endtask

  // Monitor
  bit   mon_en = 1'b0;
  int   ncyc = 0;
  pkt_t cur;
  bit   cur_act = 1'b0;
  int   byte_k = 0;
  int   t_valid = 0;
  int   t_done = 0;
  bit   prev_stall = 1'b0;
  bit   prev_err = 1'b0;
  logic [7:0] prev_data;
  logic [7:0] exp_byte;

  task automatic mon_clear();
    cur_act    = 1'b0;
    byte_k     = 0;
    prev_stall = 1'b0;
    prev_err   = 1'b0;
    pkt_q.delete();
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      ncyc++;
      if (prev_err) check("err_busy_one_cycle", {busy, pkt_start}, 0);
      prev_err = |err;
      if (pkt_start || (|err)) begin
        if (pkt_q.size() == 0) begin
          check("unexpected_packet", {err, pkt_start}, 0);
        end else begin
          cur = pkt_q.pop_front();
          if (|err) begin
            check("err_vec", err, 1 << cur.idx);
            check("err_expected", 1, cur.is_err);
            check("err_no_grant", {grant, pkt_start}, 0);
            check("err_busy", busy, 1);
          end else begin
            check("start_expected", 0, cur.is_err);
            check("grant", grant, 1 << cur.idx);
            check("pkt_len", pkt_len, cur.len);
            check("start_rd_addr", rd_addr, 0);
            cur_act = 1'b1;
            byte_k  = 0;
            t_valid = ncyc + 2;
          end
        end
      end
      if (out_valid) begin
        if (!cur_act) begin
          check("stray_valid", out_valid, 0);
        end else begin
          if (!prev_stall) check("valid_timing", ncyc, t_valid);
          else check("hold_data", out_data, prev_data);
          if (out_ready) begin
            exp_byte = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check("byte", out_data, exp_byte);
            check("pkt_last", pkt_last, (byte_k == cur.len - 1));
            byte_k++;
            if (byte_k == cur.len) t_done = ncyc + 1;
            else t_valid = ncyc + 2;
            prev_stall = 1'b0;
          end else begin
            prev_stall = 1'b1;
          end
          prev_data = out_data;
        end
      end
      if (|done) begin
        check("done_vec", done, 1 << cur.idx);
        check("done_timing", ncyc, t_done);
        check("done_bytes", byte_k, cur.len);
        check("done_grant_clear", grant, 0);
        cur_act = 1'b0;
      end
    end
  end

  // Driver
  int stall_left = 0;

  task automatic run_iter(input int ready_pct, input bit drop_en);
    bit fin;
    int owner;
    fin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pnext[i] = 0;
      req[i]   = (pcnt[i] > 0);
      req_len[8*i +: 8] = (pcnt[i] > 0) ? 8'(plen[i][0]) : 8'($urandom_range(0, 255));
    end
    for (int c = 0; c < 5000 && !fin; c++) begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && cur_act && byte_k == 1 && out_valid) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(0, 99) < ready_pct);
      end
      for (int i = 0; i < 3; i++) begin
        if (done[i] || err[i]) begin
          pnext[i]++;
          if (pnext[i] >= pcnt[i]) req[i] = 1'b0;
          else req_len[8*i +: 8] = 8'(plen[i][pnext[i]]);
        end
      end
      if (pkt_start) begin
        owner = grant[2] ? 2 : (grant[1] ? 1 : 0);
        if ($urandom_range(0, 1) == 1) req_len[8*owner +: 8] = 8'($urandom_range(0, 255));
        if (drop_en && pnext[owner] == pcnt[owner] - 1 && $urandom_range(0, 2) == 0)
          req[owner] = 1'b0;
      end
      fin = (pnext[0] >= pcnt[0]) && (pnext[1] >= pcnt[1]) && (pnext[2] >= pcnt[2]) &&
            (pkt_q.size() == 0) && (exp_q.size() == 0) && !busy;
    end
    if (!fin) begin
      check("iteration_timeout", fin, 1);
      req = 3'b000;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      mon_clear();
    end
  endtask

  task automatic set_plan(input int c0, input int c1, input int c2);
    pcnt[0] = c0;
    pcnt[1] = c1;
    pcnt[2] = c2;
  endtask

  int rl;
  int nhs;
  bit found;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected stopped");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = 3'b000;
    req_len = 24'h0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 256; k++) mem[i][k] = 8'($urandom_range(0, 255));
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_pkt", {pkt_start, pkt_len}, 0);
    check("rst_out", {out_valid, pkt_last, out_data}, 0);
    check("rst_busy_addr", {busy, rd_addr}, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single 3-byte command reply with a tied-high sink.
    mem[0][0] = 8'hAA;
    mem[0][1] = 8'hBB;
    mem[0][2] = 8'hCC;
    set_plan(1, 0, 0);
    plen[0][0] = 3;
    issue_iter();
    run_iter(100, 1'b0);

    // Events and telemetry alternate, event first after reset.
    set_plan(0, 2, 2);
    for (int j = 0; j < 4; j++) begin plen[1][j] = 1; plen[2][j] = 1; end
    issue_iter();
    run_iter(100, 1'b0);

    // Starvation: four command grants, then the event, then command again.
    set_plan(4, 1, 0);
    for (int j = 0; j < 4; j++) plen[0][j] = 1;
    plen[1][0] = 2;
    issue_iter();
    run_iter(100, 1'b0);
    set_plan(1, 0, 0);
    issue_iter();
    run_iter(100, 1'b0);

    // Illegal lengths on telemetry: zero and one past the maximum.
    set_plan(0, 0, 2);
    plen[2][0] = 0;
    plen[2][1] = MAX_LEN + 1;
    issue_iter();
    run_iter(100, 1'b0);

    // Sink stalls ten cycles on the second byte of a 4-byte packet.
    set_plan(0, 1, 0);
    plen[1][0] = 4;
    stall_left = 10;
    issue_iter();
    run_iter(100, 1'b0);
    check("stall_consumed", stall_left, 0);

    // Reset while the second of five bytes is on offer.
    mon_en = 1'b0;
    @(negedge clk);
    req = 3'b001;
    req_len[7:0] = 8'd5;
    out_ready = 1'b1;
    nhs = 0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (out_valid && nhs == 1) found = 1'b1;
      else if (out_valid && out_ready) nhs++;
    end
    check("rst_mid_reached_byte2", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_grant_done_err", {grant, done, err}, 0);
    check("midrst_pkt", {pkt_start, pkt_len}, 0);
    check("midrst_out", {out_valid, pkt_last, out_data}, 0);
    check("midrst_busy_addr", {busy, rd_addr}, 0);
    rst = 1'b0;
    model_reset();
    mon_clear();
    set_plan(1, 0, 0);
    plen[0][0] = 5;
    issue_iter();
    mon_en = 1'b1;
    run_iter(100, 1'b0);

    // Randomized request mixes.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 3; i++) begin
        pcnt[i] = $urandom_range(0, 3);
        for (int k = 0; k < 64; k++) mem[i][k] = 8'($urandom_range(0, 255));
        for (int j = 0; j < 4; j++) begin
          rl = $urandom_range(0, 19);
          if (rl == 0)      plen[i][j] = 0;
          else if (rl == 1) plen[i][j] = $urandom_range(MAX_LEN + 1, 255);
          else if (rl == 2) plen[i][j] = MAX_LEN;
          else              plen[i][j] = $urandom_range(1, 8);
        end
      end
      if (pcnt[0] + pcnt[1] + pcnt[2] == 0) pcnt[it % 3] = 2;
      issue_iter();
      run_iter($urandom_range(40, 100), 1'b1);
    end

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
